// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared constants and types for the text buffer serializer.
//   ROW_STRIDE : address stride between text rows (columns per physical row)
//   ADDR_W     : text RAM address width, {row[3:0], col[4:0]}
//   CHAR_W     : character width
//   CHAR_NL    : line feed emitted at row ends when newlines are enabled
//   CHAR_EMPTY : value of an unused text cell
//   state_t    : scanner FSM state encoding
// -----------------------------------------------------------------------------
package text_pkg;

   localparam int ROW_STRIDE = 32;
   localparam int ADDR_W     = 9;
   localparam int CHAR_W     = 8;
   localparam int COL_W      = $clog2(ROW_STRIDE);
   localparam int ROW_W      = ADDR_W - COL_W;

   localparam logic [CHAR_W-1:0] CHAR_NL    = 8'h0A;
   localparam logic [CHAR_W-1:0] CHAR_EMPTY = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WAIT    = 3'd2,
      ST_EMIT    = 3'd3,
      ST_NEWLINE = 3'd4,
      ST_FINISH  = 3'd5
   } state_t;

   // Pack a row/column cursor into a text RAM address.
   function automatic logic [ADDR_W-1:0] make_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/text_scan_cursor.sv
// -----------------------------------------------------------------------------
// text_scan_cursor
// Row/column cursor over the used part of the text buffer. Columns run
// 0..COLS-1, rows 0..ROWS-1; stepping past the last cell wraps to 0/0.
//   clk, rst      : clock, asynchronous active-high reset
//   i_clear       : synchronous return to row 0, column 0
//   i_inc         : advance one cell
//   o_row, o_col  : current cursor position
//   o_last_col    : cursor sits in the last used column of its row
//   o_last_cell   : cursor sits in the last used cell of the buffer
// -----------------------------------------------------------------------------
module text_scan_cursor
   import text_pkg::*;
#(
   parameter int ROWS = 15,
   parameter int COLS = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_last_col,
   output logic             o_last_cell
);

   logic [ROW_W-1:0] r_row;
   logic [COL_W-1:0] r_col;

   assign o_row       = r_row;
   assign o_col       = r_col;
   assign o_last_col  = (r_col == COL_W'(COLS - 1));
   assign o_last_cell = o_last_col && (r_row == ROW_W'(ROWS - 1));

   // Cursor position: clear has priority over advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row <= {ROW_W{1'b0}};
         r_col <= {COL_W{1'b0}};
      end else if (i_clear) begin
         r_row <= {ROW_W{1'b0}};
         r_col <= {COL_W{1'b0}};
      end else if (i_inc) begin
         if (o_last_cell) begin
            r_row <= {ROW_W{1'b0}};
            r_col <= {COL_W{1'b0}};
         end else if (o_last_col) begin
            r_row <= r_row + ROW_W'(1);
            r_col <= {COL_W{1'b0}};
         end else begin
            r_row <= r_row;
            r_col <= r_col + COL_W'(1);
         end
      end else begin
         r_row <= r_row;
         r_col <= r_col;
      end
   end

endmodule

// File: rtl/text_reader.sv
// -----------------------------------------------------------------------------
// text_reader
// Serializes a text buffer held in a synchronous-read RAM into a
// valid/ready byte stream. Empty cells (0x00) are skipped; only the first
// COLS columns of each of ROWS rows are read.
//
// Optional feature: define TEXT_READER_NEWLINE_EN to emit a 0x0A character
// (with full handshake) after every row.
//
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle scan request, honoured only when idle
//   ram_addr   : text RAM address {row, col}
//   ram_re     : RAM read strobe, data returned on ram_data one cycle later
//   ram_data   : character from the RAM
//   out_data   : streamed character
//   out_valid  : out_data valid, held until out_ready
//   out_ready  : downstream accept
//   busy       : scan in progress
//   done       : one-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module text_reader
   import text_pkg::*;
#(
   parameter int ROWS = 15,
   parameter int COLS = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_re,
   input  logic [CHAR_W-1:0] ram_data,
   output logic [CHAR_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   state_t            r_state;
   logic              r_ram_re;
   logic [CHAR_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_done;
`ifdef TEXT_READER_NEWLINE_EN
   logic              r_last_row;
`endif

   logic [ROW_W-1:0]  w_row;
   logic [COL_W-1:0]  w_col;
   logic              w_last_col;
   logic              w_last_cell;
   logic              w_clear;
   logic              w_inc;

   // A cell is finished either when it reads back empty or when its
   // character has been accepted downstream.
   assign w_clear = (r_state == ST_IDLE) && start;
   assign w_inc   = ((r_state == ST_WAIT) && (ram_data == CHAR_EMPTY)) ||
                    ((r_state == ST_EMIT) && out_ready);

   text_scan_cursor #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_cursor (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_clear),
      .i_inc       (w_inc),
      .o_row       (w_row),
      .o_col       (w_col),
      .o_last_col  (w_last_col),
      .o_last_cell (w_last_cell)
   );

   // The cursor only moves after a cell is finished, so it already holds
   // the address of the cell being read whenever ram_re is high.
   assign ram_addr  = make_addr(w_row, w_col);
   assign ram_re    = r_ram_re;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign done      = r_done;

   // Scanner FSM and its registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ram_re    <= 1'b0;
         r_out_data  <= CHAR_EMPTY;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef TEXT_READER_NEWLINE_EN
         r_last_row  <= 1'b0;
`endif
      end else begin
         r_ram_re <= 1'b0;
         r_done   <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_READ;
                  r_ram_re <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            ST_READ: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ram_data != CHAR_EMPTY) begin
                  r_state     <= ST_EMIT;
                  r_out_data  <= ram_data;
                  r_out_valid <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
`ifdef TEXT_READER_NEWLINE_EN
            ST_NEWLINE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_last_row) begin
                     r_state <= ST_FINISH;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= ST_READ;
                     r_ram_re <= 1'b1;
                  end
               end
            end
`endif
            ST_FINISH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase

         // Cell finished: pick the follow-on state. These assignments come
         // after the case so they override the per-state defaults above.
         if (w_inc) begin
            if (!w_last_col) begin
               r_state  <= ST_READ;
               r_ram_re <= 1'b1;
`ifdef TEXT_READER_NEWLINE_EN
            end else begin
               r_state     <= ST_NEWLINE;
               r_out_data  <= CHAR_NL;
               r_out_valid <= 1'b1;
               r_last_row  <= w_last_cell;
            end
`else
            end else if (w_last_cell) begin
               r_state <= ST_FINISH;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_state  <= ST_READ;
               r_ram_re <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: doc/text_reader.md
TEXT_READER -- requirements
Module: text_reader

Interface
REQ-001 Parameter ROWS, default 15, number of text rows scanned.
REQ-002 Parameter COLS, default 20, number of used columns per row (row stride fixed at 32).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to serialize the whole text buffer.
REQ-006 ram_addr  output  9  text RAM read address {row[3:0], col[4:0]}.
REQ-007 ram_re  output  1  read strobe; ram_data valid the cycle after ram_re=1.
REQ-008 ram_data  input  8  character read from text RAM (0x00 = empty cell).
REQ-009 out_data  output  8  streamed character.
REQ-010 out_valid  output  1  out_data valid; held until accepted.
REQ-011 out_ready  input  1  downstream accept; transfer when out_valid and out_ready both 1.
REQ-012 busy  output  1  high from the cycle after accepted start until done.
REQ-013 done  output  1  one-cycle pulse when the scan completes.

Function
REQ-014 The FSM SHALL have states IDLE, READ, WAIT, EMIT, NEWLINE, FINISH.
REQ-015 IDLE: start=1 -> row=0, col=0, go READ; start while not IDLE SHALL be ignored.
REQ-016 READ: ram_re=1, ram_addr={row,col}; next state WAIT unconditionally.
REQ-017 WAIT: ram_data captured; nonzero -> EMIT with out_data=ram_data; zero -> advance cursor, no output.
REQ-018 EMIT: out_valid=1, out_data stable; on out_ready=1 advance cursor; otherwise hold indefinitely.
REQ-019 Cursor advance: col<COLS-1 -> col+1, READ; col=COLS-1 -> col=0, row+1, go NEWLINE (macro on) or READ/FINISH (macro off).
REQ-020 After row ROWS-1 completes the FSM SHALL enter FINISH instead of READ; columns 20..31 SHALL never be addressed.
REQ-021 FINISH: done=1 for exactly one cycle, busy=0 that cycle, next state IDLE.
REQ-022 Throughput: one RAM read per 2 cycles minimum; empty cell costs 2 cycles, char costs >=3 cycles.
REQ-023 ram_re SHALL be 0 outside READ; out_valid SHALL be 0 outside EMIT/NEWLINE.
REQ-024 Fully empty buffer SHALL emit no characters (only newlines if enabled) then pulse done.

Reset
REQ-025 rst=1 at any time SHALL force IDLE, row=col=0, ram_addr=0, ram_re=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-026 Reset mid-scan SHALL abandon the stream without completing a pending transfer or pulsing done.

Configuration
REQ-027 Macro TEXT_READER_NEWLINE_EN defined: NEWLINE state emits out_data=0x0A with valid/ready handshake after every row, then READ or FINISH.
REQ-028 Macro undefined: NEWLINE state absent; row end goes directly to READ or FINISH; no 0x0A ever emitted.

Structure
REQ-029 Shared package text_pkg SHALL hold ROW_STRIDE=32, ADDR_W=9, CHAR_W=8, CHAR_NL=8'h0A, CHAR_EMPTY=8'h00 and the state enum type.
REQ-030 Row/column counter with wrap and last-cell flag SHALL be sub-module text_scan_cursor (inc, clear, row, col, last_col, last_cell).

Verification
REQ-031 RAM with 'H'(0x48) at 0x000, 'i'(0x69) at 0x001, rest 0, out_ready=1, macro off -> stream 0x48,0x69 then done pulse; no address with col>=20 observed.
REQ-032 Same RAM, macro on -> 0x48,0x69,0x0A followed by fourteen 0x0A, then done.
REQ-033 out_ready held 0 for 10 cycles during 'H' -> out_valid=1, out_data=0x48 stable all 10 cycles, no extra RAM read.
REQ-034 All-empty RAM, macro off -> zero transfers, done after exactly 2*300+2 cycles from start.
REQ-035 rst asserted in EMIT of cell 0x123 -> next cycle out_valid=0, busy=0; subsequent start rescans from 0x000.
REQ-036 start pulsed again while busy -> ignored; exactly one done pulse per accepted start.
